// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions for the ADC protection path.
// Contents:
//   DATA_W / CW_W    : data and codeword widths
//   *_POS            : bit index of each codeword field (bit i = Hamming position i+1)
//   hamming74_encode : pure encoder, also used by the downstream decoder
package hamming_pkg;

  localparam int DATA_W = 4;
  localparam int CW_W   = 8;

  localparam int P1_POS  = 0;
  localparam int P2_POS  = 1;
  localparam int D0_POS  = 2;
  localparam int P4_POS  = 3;
  localparam int D1_POS  = 4;
  localparam int D2_POS  = 5;
  localparam int D3_POS  = 6;
  localparam int PAR_POS = 7;

  // 7-bit Hamming codeword; the overall parity bit is added by the caller.
  function automatic logic [CW_W-2:0] hamming74_encode(input logic [DATA_W-1:0] d);
    logic [CW_W-2:0] c;
    c          = '0;
    c[D0_POS]  = d[0];
    c[D1_POS]  = d[1];
    c[D2_POS]  = d[2];
    c[D3_POS]  = d[3];
    c[P1_POS]  = d[0] ^ d[1] ^ d[3];
    c[P2_POS]  = d[0] ^ d[2] ^ d[3];
    c[P4_POS]  = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

endpackage

// File: rtl/hamming74_enc.sv
// Combinational Hamming(7,4) encoder with optional SECDED overall parity.
// Ports:
//   data [3:0] : input data bits d0..d3
//   cw   [7:0] : [6:0] Hamming(7,4) codeword, [7] overall parity or 0
// Build option: define HAMMING_SECDED_EN to drive cw[7] with even overall
// parity across all 8 bits; otherwise cw[7] is tied to 0.
module hamming74_enc
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic [CW_W-1:0]   cw
);

  logic [CW_W-2:0] code7;

  assign code7          = hamming74_encode(data);
  assign cw[CW_W-2:0]   = code7;

`ifdef HAMMING_SECDED_EN
  assign cw[PAR_POS] = ^code7;
`else
  assign cw[PAR_POS] = 1'b0;
`endif

endmodule

// File: rtl/adc_hamming_encoder.sv
// Captures ADC codes on a sample strobe, Hamming-encodes them and buffers the
// codewords in a first-word-fall-through FIFO with a valid/ready output.
// Samples arriving while the FIFO is full (and not popping) are dropped and
// counted.
// Parameters: DEPTH (FIFO entries, power of two, >= 2), CNT_W (drop counter width).
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   adc_code     : 4-bit ADC code, captured when sample_en is high
//   sample_en    : capture strobe
//   clr_stats    : synchronous clear of overflow / drop_count
//   cw_data      : registered FIFO head codeword
//   cw_valid     : cw_data holds the FIFO head
//   cw_ready     : consumer accepts the head
//   fifo_level   : occupancy 0..DEPTH
//   overflow     : sticky drop flag
//   drop_count   : saturating count of dropped samples
// Build option: HAMMING_SECDED_EN (see hamming74_enc) sets cw_data[7].
module adc_hamming_encoder
  import hamming_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        adc_code,
  input  logic                     sample_en,
  input  logic                     clr_stats,
  output logic [CW_W-1:0]          cw_data,
  output logic                     cw_valid,
  input  logic                     cw_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [CW_W-1:0] enc_cw;
  logic [CW_W-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   rd_ptr_next;
  logic [LW-1:0]   level;
  logic [LW-1:0]   level_after_pop;
  logic [LW-1:0]   level_next;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;
  logic            bypass;
  logic [CW_W-1:0] head_next;

  hamming74_enc u_enc (
    .data (adc_code),
    .cw   (enc_cw)
  );

  assign fifo_level = level;

  always_comb begin
    full            = (level == LW'(DEPTH));
    pop             = cw_valid & cw_ready;
    push            = sample_en & (~full | pop);
    drop            = sample_en & full & ~pop;
    level_after_pop = level - LW'(pop);
    level_next      = level_after_pop + LW'(push);
    rd_ptr_next     = pop ? rd_ptr + PW'(1) : rd_ptr;
    // A word pushed into an otherwise-empty FIFO becomes the head straight
    // away; its storage slot is only written on this same edge, so take it
    // from the encoder instead of the array.
    bypass          = push & (level_after_pop == '0);
    head_next       = '0;
    if (bypass)
      head_next = enc_cw;
    else if (level_next != '0)
      head_next = mem[rd_ptr_next];
  end

  // Storage: data only, no reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= enc_cw;
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      cw_valid <= 1'b0;
      cw_data  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      rd_ptr   <= rd_ptr_next;
      level    <= level_next;
      cw_valid <= (level_next != '0);
      cw_data  <= head_next;
    end
  end

  // Drop statistics: a drop in the same cycle as clr_stats wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= clr_stats ? CNT_W'(1) : sat_inc(drop_count);
    end else if (clr_stats) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: doc/adc_hamming_encoder.md
# adc_hamming_encoder

Sits directly downstream of the flash ADC's priority encoder, on the protection side of the ADC data path. Captures the 4-bit ADC code on a sample strobe, encodes it into a Hamming(7,4) codeword and buffers it in a small first-word-fall-through FIFO. Delivers codewords to the channel/decoder side over a valid/ready handshake. Counts and flags samples lost to back-pressure.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the saturating drop counter.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- adc_code  in  4  ADC binary output; legal values are 0..8, and 9..15 are encoded unchanged.
- sample_en  in  1  one-cycle strobe: capture adc_code this cycle.
- clr_stats  in  1  synchronous clear of overflow and drop_count.
- cw_data  out  8  codeword; [6:0] Hamming(7,4), [7] overall parity or 0 (see Configuration).
- cw_valid  out  1  cw_data holds the FIFO head.
- cw_ready  in  1  consumer accepts the head this cycle.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a sample was dropped.
- drop_count  out  CNT_W  number of dropped samples, saturating.

## Operation
- Encoding uses data bits d0..d3 = adc_code[0..3].
  - p1 = d0^d1^d3, p2 = d0^d2^d3, p4 = d1^d2^d3.
  - cw[6:0] = {d3,d2,d1,p4,d0,p2,p1}, i.e. bit i is Hamming position i+1.
- Push occurs when sample_en is high and (level < DEPTH or pop occurs in the same cycle).
- Pop occurs when cw_valid && cw_ready.
- Simultaneous push and pop:
  - At full: both take effect and the level stays DEPTH.
  - At empty: only the push takes effect, because cw_valid was low. The word appears the next cycle.
- Drop occurs when sample_en is high, level == DEPTH and there is no pop. The new sample is discarded and FIFO contents are unchanged.
  - overflow is set to 1.
  - drop_count increments, saturating at 2^CNT_W-1.
- clr_stats zeroes overflow and drop_count. If a drop happens in the same cycle, the drop wins: overflow=1 and drop_count=1.
- Read/write pointers wrap modulo DEPTH. Level is tracked by a separate counter, not inferred from the pointers.
- cw_data is registered from FIFO storage. It is stable while cw_valid is high and cw_ready is low.
- Once cw_valid is high it stays high until a pop.
- cw_ready is ignored while cw_valid is low.

## Timing
- Reset values (asynchronous, immediate):
  - cw_valid=0, cw_data=0, fifo_level=0, overflow=0, drop_count=0.
  - Pointers are 0 and the FIFO is emptied.
- Latency: a sample_en in cycle N into an empty FIFO gives cw_valid=1 with its codeword in cycle N+1.
- Throughput: one push and one pop per cycle, sustained.
- fifo_level, overflow and drop_count update on the edge ending the cycle that caused the change.
- Reset asserted mid-stream discards all buffered words. No partial transfer completes.

## Configuration
- HAMMING_SECDED_EN defined:
  - cw_data[7] = XOR of cw[6:0], giving even overall parity across all 8 bits.
  - This enables SECDED decoding downstream.
- Macro not defined:
  - cw_data[7] is tied to 0 and the parity logic is absent.
  - Port width stays 8 in both builds.

## Structure
- Package hamming_pkg:
  - DATA_W=4, CW_W=8.
  - Codeword bit-position localparams.
  - A pure encode function shared with the downstream decoder.
- One sub-module, hamming74_enc: combinational 4-to-8 encoder, which also contains the SECDED parity under the macro.
- The FIFO, occupancy counter and statistics stay in the top module.

## Test plan
- Reset, then adc_code=5 with a single sample_en:
  - Next cycle cw_valid=1 and cw_data=8'h2D in both builds.
  - After a pop with cw_ready=1, cw_valid=0 and fifo_level=0.
- adc_code=1 and adc_code=8 with cw_ready held high:
  - Code 1 gives cw_data=8'h87 with HAMMING_SECDED_EN and 8'h07 without.
  - Code 8 gives cw_data=8'h4B in both builds.
- cw_ready=0, then 6 strobes with codes 0..5:
  - fifo_level=4, overflow=1, drop_count=2.
  - Draining yields the codewords for codes 0..3 in order.
- FIFO full, then sample_en and cw_ready asserted in the same cycle:
  - Level stays 4 and drop_count is unchanged.
  - The newest code is delivered last.
- 300 drops with cw_ready=0:
  - drop_count saturates at 255.
  - clr_stats gives overflow=0 and drop_count=0.
  - clr_stats together with a drop gives overflow=1 and drop_count=1.
- Assert rst with 3 words buffered and cw_valid=1:
  - All outputs read 0 immediately, without waiting for clk.
  - After release, the first new sample appears with a latency of 1.
